// File: rtl/wb_pkg.sv
// Shared types for the write-back scheduler: FSM states, latched layer
// configuration bundle and the per-tile burst length helper.
package wb_pkg;

   localparam int LEN_W_DEF = 13;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TILE,
      CMD,
      KICK,
      RUN,
      ACK
   } wb_state_t;

   typedef struct packed {
      logic [3:0] layer_type;
      logic       pooling;
      logic       relu;
      logic [3:0] ch_num;
      logic [3:0] pix_num;
      logic [3:0] row_num;
      logic [5:0] shift;
   } wb_conf_t;

   // Words per tile burst; each index is count-1, so the product is at
   // most 16*16*16 and always fits.
   function automatic logic [LEN_W_DEF-1:0] burst_len(input wb_conf_t c);
      logic [LEN_W_DEF-1:0] a;
      logic [LEN_W_DEF-1:0] b;
      logic [LEN_W_DEF-1:0] d;
      a = LEN_W_DEF'(c.ch_num) + LEN_W_DEF'(1);
      b = LEN_W_DEF'(c.pix_num) + LEN_W_DEF'(1);
      d = LEN_W_DEF'(c.row_num) + LEN_W_DEF'(1);
      burst_len = a * b * d;
   endfunction

endpackage

// File: rtl/wb_sched_cmd_chan.sv
// One DDR write-command channel: load registers addr/len and raises valid,
// valid drops on the valid&ready handshake, sent stays high until next load.
// Ports: clk, rst (sync, active-low), load/load_addr/load_len, ready,
// valid/addr/len (registered command), sent.
module wb_cmd_chan #(
   parameter int AW = 32,
   parameter int LW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [AW-1:0] load_addr,
   input  logic [LW-1:0] load_len,
   input  logic          ready,
   output logic          valid,
   output logic [AW-1:0] addr,
   output logic [LW-1:0] len,
   output logic          sent
);

   logic          valid_q, valid_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] len_q, len_d;
   logic          sent_q, sent_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      len_d   = len_q;
      sent_d  = sent_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = load_addr;
         len_d   = load_len;
         sent_d  = 1'b0;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
         sent_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         sent_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         sent_q  <= sent_d;
      end
   end

   assign valid = valid_q;
   assign addr  = addr_q;
   assign len   = len_q;
   assign sent  = sent_q;

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: per output tile, waits for a filled buffer, issues
// DDR write commands, runs ddr2pe_dg, then releases the buffer.
// Ports: start/done layer control, conf_* layer config, tile_valid/tile_ack
// PE buffer handshake, dg_* generator control, ddr1/ddr2 command channels.
module wb_sched
   import wb_pkg::*;
#(
   parameter int DDR_AW = 32,
   parameter int TILE_W = 8,
   parameter int LEN_W  = wb_pkg::LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              done,
   input  logic [3:0]        conf_layer_type,
   input  logic              conf_pooling,
   input  logic              conf_relu,
   input  logic [3:0]        conf_ch_num,
   input  logic [3:0]        conf_pix_num,
   input  logic [3:0]        conf_row_num,
   input  logic [5:0]        conf_shift,
   input  logic [TILE_W-1:0] conf_tile_num,
   input  logic [DDR_AW-1:0] conf_ddr1_base,
   input  logic [DDR_AW-1:0] conf_ddr2_base,
   input  logic [DDR_AW-1:0] conf_tile_stride,
   input  logic              tile_valid,
   output logic              tile_ack,
   output logic              dg_start,
   input  logic              dg_done,
   output logic [3:0]        dg_layer_type,
   output logic              dg_pooling,
   output logic              dg_relu,
   output logic [3:0]        dg_ch_num,
   output logic [3:0]        dg_pix_num,
   output logic [3:0]        dg_row_num,
   output logic [5:0]        dg_shift,
   output logic [DDR_AW-1:0] ddr1_cmd_addr,
   output logic [DDR_AW-1:0] ddr2_cmd_addr,
   output logic [LEN_W-1:0]  ddr1_cmd_len,
   output logic [LEN_W-1:0]  ddr2_cmd_len,
   output logic              ddr1_cmd_valid,
   output logic              ddr2_cmd_valid,
   input  logic              ddr1_cmd_ready,
   input  logic              ddr2_cmd_ready
);

   wb_state_t         state_q, state_d;
   wb_conf_t          conf_q, conf_d, conf_in;
   logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
   logic [TILE_W-1:0] tile_num_q, tile_num_d;
   logic [DDR_AW-1:0] addr1_q, addr1_d;
   logic [DDR_AW-1:0] addr2_q, addr2_d;
   logic [DDR_AW-1:0] stride_q, stride_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              done_q, done_d;
   logic              ack_q, ack_d;
   logic              kick_q, kick_d;
   logic              first_q, first_d;

   logic load1, load2;
   logic sent1, sent2;
   logic need2, ok1, ok2, last;

   assign conf_in = '{
      layer_type: conf_layer_type,
      pooling:    conf_pooling,
      relu:       conf_relu,
      ch_num:     conf_ch_num,
      pix_num:    conf_pix_num,
      row_num:    conf_row_num,
      shift:      conf_shift
   };

   assign need2 = ~conf_q.layer_type[1];
   // A channel counts as finished when it handshakes in this very cycle,
   // so dg_start follows the last handshake by exactly one cycle.
   assign ok1   = sent1 | (ddr1_cmd_valid & ddr1_cmd_ready);
   assign ok2   = ~need2 | sent2 | (ddr2_cmd_valid & ddr2_cmd_ready);
   assign last  = (tile_cnt_q == tile_num_q);

   always_comb begin
      state_d    = state_q;
      conf_d     = conf_q;
      tile_cnt_d = tile_cnt_q;
      tile_num_d = tile_num_q;
      addr1_d    = addr1_q;
      addr2_d    = addr2_q;
      stride_d   = stride_q;
      len_d      = len_q;
      done_d     = done_q;
      ack_d      = 1'b0;
      kick_d     = 1'b0;
      first_d    = 1'b0;
      load1      = 1'b0;
      load2      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               conf_d     = conf_in;
               tile_num_d = conf_tile_num;
               stride_d   = conf_tile_stride;
               addr1_d    = conf_ddr1_base;
               addr2_d    = conf_ddr2_base;
               len_d      = LEN_W'(burst_len(conf_in));
               tile_cnt_d = '0;
               done_d     = 1'b0;
               state_d    = WAIT_TILE;
            end
         end
         WAIT_TILE: begin
            if (tile_valid) begin
               load1   = 1'b1;
               load2   = need2;
               state_d = CMD;
            end
         end
         CMD: begin
            if (ok1 && ok2) begin
               kick_d  = 1'b1;
               state_d = KICK;
            end
         end
         KICK: begin
            first_d = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            // dg_done may still be high from the previous tile during the
            // first RUN cycle, so it is only trusted afterwards.
            if (!first_q && dg_done) begin
               ack_d   = 1'b1;
               done_d  = last;
               state_d = ACK;
            end
         end
         ACK: begin
            addr1_d = addr1_q + stride_q;
            addr2_d = addr2_q + stride_q;
            if (last) begin
               state_d = IDLE;
            end else begin
               tile_cnt_d = tile_cnt_q + TILE_W'(1);
               state_d    = WAIT_TILE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         conf_q     <= '0;
         tile_cnt_q <= '0;
         tile_num_q <= '0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         stride_q   <= '0;
         len_q      <= '0;
         done_q     <= 1'b1;
         ack_q      <= 1'b0;
         kick_q     <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         conf_q     <= conf_d;
         tile_cnt_q <= tile_cnt_d;
         tile_num_q <= tile_num_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
         stride_q   <= stride_d;
         len_q      <= len_d;
         done_q     <= done_d;
         ack_q      <= ack_d;
         kick_q     <= kick_d;
         first_q    <= first_d;
      end
   end

   wb_cmd_chan #(.AW(DDR_AW), .LW(LEN_W)) u_ch1 (
      .clk       (clk),
      .rst       (rst),
      .load      (load1),
      .load_addr (addr1_q),
      .load_len  (len_q),
      .ready     (ddr1_cmd_ready),
      .valid     (ddr1_cmd_valid),
      .addr      (ddr1_cmd_addr),
      .len       (ddr1_cmd_len),
      .sent      (sent1)
   );

   wb_cmd_chan #(.AW(DDR_AW), .LW(LEN_W)) u_ch2 (
      .clk       (clk),
      .rst       (rst),
      .load      (load2),
      .load_addr (addr2_q),
      .load_len  (len_q),
      .ready     (ddr2_cmd_ready),
      .valid     (ddr2_cmd_valid),
      .addr      (ddr2_cmd_addr),
      .len       (ddr2_cmd_len),
      .sent      (sent2)
   );

   assign done          = done_q;
   assign tile_ack      = ack_q;
   assign dg_start      = kick_q;
   assign dg_layer_type = conf_q.layer_type;
   assign dg_pooling    = conf_q.pooling;
   assign dg_relu       = conf_q.relu;
   assign dg_ch_num     = conf_q.ch_num;
   assign dg_pix_num    = conf_q.pix_num;
   assign dg_row_num    = conf_q.row_num;
   assign dg_shift      = conf_q.shift;

endmodule

// File: tb/tb_wb_sched.sv
// Self-checking bench for wb_sched: table of directed layers, random layers
// against a cycle-timeline model, and a mid-burst reset sequence.
module tb_wb_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        done;
   logic [3:0]  conf_layer_type = '0;
   logic        conf_pooling = 1'b0;
   logic        conf_relu = 1'b0;
   logic [3:0]  conf_ch_num = '0;
   logic [3:0]  conf_pix_num = '0;
   logic [3:0]  conf_row_num = '0;
   logic [5:0]  conf_shift = '0;
   logic [7:0]  conf_tile_num = '0;
   logic [31:0] conf_ddr1_base = '0;
   logic [31:0] conf_ddr2_base = '0;
   logic [31:0] conf_tile_stride = '0;
   logic        tile_valid = 1'b0;
   logic        tile_ack;
   logic        dg_start;
   logic        dg_done = 1'b0;
   logic [3:0]  dg_layer_type;
   logic        dg_pooling;
   logic        dg_relu;
   logic [3:0]  dg_ch_num;
   logic [3:0]  dg_pix_num;
   logic [3:0]  dg_row_num;
   logic [5:0]  dg_shift;
   logic [31:0] ddr1_cmd_addr;
   logic [31:0] ddr2_cmd_addr;
   logic [12:0] ddr1_cmd_len;
   logic [12:0] ddr2_cmd_len;
   logic        ddr1_cmd_valid;
   logic        ddr2_cmd_valid;
   logic        ddr1_cmd_ready = 1'b0;
   logic        ddr2_cmd_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_sched dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .done             (done),
      .conf_layer_type  (conf_layer_type),
      .conf_pooling     (conf_pooling),
      .conf_relu        (conf_relu),
      .conf_ch_num      (conf_ch_num),
      .conf_pix_num     (conf_pix_num),
      .conf_row_num     (conf_row_num),
      .conf_shift       (conf_shift),
      .conf_tile_num    (conf_tile_num),
      .conf_ddr1_base   (conf_ddr1_base),
      .conf_ddr2_base   (conf_ddr2_base),
      .conf_tile_stride (conf_tile_stride),
      .tile_valid       (tile_valid),
      .tile_ack         (tile_ack),
      .dg_start         (dg_start),
      .dg_done          (dg_done),
      .dg_layer_type    (dg_layer_type),
      .dg_pooling       (dg_pooling),
      .dg_relu          (dg_relu),
      .dg_ch_num        (dg_ch_num),
      .dg_pix_num       (dg_pix_num),
      .dg_row_num       (dg_row_num),
      .dg_shift         (dg_shift),
      .ddr1_cmd_addr    (ddr1_cmd_addr),
      .ddr2_cmd_addr    (ddr2_cmd_addr),
      .ddr1_cmd_len     (ddr1_cmd_len),
      .ddr2_cmd_len     (ddr2_cmd_len),
      .ddr1_cmd_valid   (ddr1_cmd_valid),
      .ddr2_cmd_valid   (ddr2_cmd_valid),
      .ddr1_cmd_ready   (ddr1_cmd_ready),
      .ddr2_cmd_ready   (ddr2_cmd_ready)
   );

   typedef struct {
      logic [3:0]  lt;
      logic [3:0]  ch;
      logic [3:0]  pix;
      logic [3:0]  row;
      logic [7:0]  tiles;
      logic [31:0] b1;
      logic [31:0] b2;
      logic [31:0] stride;
      int          d1;
      int          d2;
      int          tv;
      int          dg;
      bit          poke;
      logic [12:0] exp_len;
      logic [31:0] exp_l1;
      logic [31:0] exp_l2;
      int          exp_acks;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chkv(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chkv(nm, 64'(act), 64'(exp));
   endtask

   function automatic logic [23:0] dg_cfg();
      return {dg_layer_type, dg_pooling, dg_relu, dg_ch_num,
              dg_pix_num, dg_row_num, dg_shift};
   endfunction

   // Expected behaviour is a per-tile timeline derived from the timing
   // rules: w=WAIT_TILE entry, c=cmd valid rise, h1/h2=handshakes,
   // k=dg_start, a=tile_ack. Every slot is compared against it.
   task automatic run_layer(input vec_t v, input bit rnd, output int acks,
                            output logic [12:0] llen,
                            output logic [31:0] l1,
                            output logic [31:0] l2);
      int n, cur, len, last_s;
      int w[16], c[16], h1[16], h2[16], k[16], a[16];
      int tva[16], d1a[16], d2a[16], dga[16];
      bit need2;
      logic [23:0] cfg;
      logic [31:0] ea1, ea2;
      logic        pool, relu;
      logic [5:0]  shift;
      n     = int'(v.tiles) + 1;
      need2 = !v.lt[1];
      len   = (int'(v.ch) + 1) * (int'(v.pix) + 1) * (int'(v.row) + 1);
      acks  = 0;
      llen  = '0;
      l1    = '0;
      l2    = '0;
      cfg   = '0;
      pool  = 1'($urandom);
      relu  = 1'($urandom);
      shift = 6'($urandom);
      for (int t = 0; t < n; t++) begin
         d1a[t] = rnd ? int'($urandom_range(0, 5)) : v.d1;
         d2a[t] = rnd ? int'($urandom_range(0, 5)) : v.d2;
         tva[t] = rnd ? int'($urandom_range(0, 10)) : v.tv;
         dga[t] = rnd ? int'($urandom_range(0, 6)) : v.dg;
         w[t]   = (t == 0) ? 1 : a[t-1] + 1;
         c[t]   = w[t] + tva[t] + 1;
         h1[t]  = c[t] + d1a[t];
         h2[t]  = need2 ? c[t] + d2a[t] : c[t];
         k[t]   = ((h1[t] > h2[t]) ? h1[t] : h2[t]) + 1;
         a[t]   = ((dga[t] > 2) ? k[t] + dga[t] : k[t] + 2) + 1;
      end
      last_s = a[n-1] + 2;
      cur    = 0;
      for (int s = 0; s <= last_s; s++) begin
         if (cur < n - 1 && s > a[cur]) cur++;
         chk1("ddr1_valid", ddr1_cmd_valid, s >= c[cur] && s <= h1[cur]);
         chk1("ddr2_valid", ddr2_cmd_valid,
              need2 && s >= c[cur] && s <= h2[cur]);
         chk1("dg_start", dg_start, s == k[cur]);
         chk1("tile_ack", tile_ack, s == a[cur]);
         chk1("done", done, s == 0 || s >= a[n-1]);
         if (s > 0) chkv("dg_cfg", 64'(dg_cfg()), 64'(cfg));
         ea1 = v.b1 + v.stride * 32'(cur);
         ea2 = v.b2 + v.stride * 32'(cur);
         if (ddr1_cmd_valid) begin
            chkv("ddr1_addr", 64'(ddr1_cmd_addr), 64'(ea1));
            chkv("ddr1_len", 64'(ddr1_cmd_len), 64'(len));
         end
         if (ddr2_cmd_valid) begin
            chkv("ddr2_addr", 64'(ddr2_cmd_addr), 64'(ea2));
            chkv("ddr2_len", 64'(ddr2_cmd_len), 64'(len));
         end
         if (tile_ack) acks++;
         if (s == 0) begin
            conf_layer_type  = v.lt;
            conf_pooling     = pool;
            conf_relu        = relu;
            conf_ch_num      = v.ch;
            conf_pix_num     = v.pix;
            conf_row_num     = v.row;
            conf_shift       = shift;
            conf_tile_num    = v.tiles;
            conf_ddr1_base   = v.b1;
            conf_ddr2_base   = v.b2;
            conf_tile_stride = v.stride;
            cfg   = {v.lt, pool, relu, v.ch, v.pix, v.row, shift};
            start = 1'b1;
         end else begin
            start = v.poke && s <= a[n-1] &&
                    (s == c[cur] || s == k[cur] || s == a[cur]);
            conf_layer_type  = 4'($urandom);
            conf_pooling     = 1'($urandom);
            conf_relu        = 1'($urandom);
            conf_ch_num      = 4'($urandom);
            conf_pix_num     = 4'($urandom);
            conf_row_num     = 4'($urandom);
            conf_shift       = 6'($urandom);
            conf_tile_num    = 8'($urandom);
            conf_ddr1_base   = $urandom;
            conf_ddr2_base   = $urandom;
            conf_tile_stride = $urandom;
         end
         tile_valid     = s >= w[cur] + tva[cur] && s <= a[cur];
         ddr1_cmd_ready = s >= c[cur] + d1a[cur] && s <= a[cur];
         ddr2_cmd_ready = need2 ? (s >= c[cur] + d2a[cur] && s <= a[cur])
                                : 1'($urandom);
         dg_done        = s >= k[cur] + dga[cur] && s <= a[cur];
         if (ddr1_cmd_valid && ddr1_cmd_ready) begin
            l1   = ddr1_cmd_addr;
            llen = ddr1_cmd_len;
         end
         if (ddr2_cmd_valid && ddr2_cmd_ready) l2 = ddr2_cmd_addr;
         step();
      end
      start          = 1'b0;
      tile_valid     = 1'b0;
      ddr1_cmd_ready = 1'b0;
      ddr2_cmd_ready = 1'b0;
      dg_done        = 1'b0;
   endtask

   vec_t        tbl[6];
   vec_t        rv;
   int          acks;
   logic [12:0] llen;
   logic [31:0] l1, l2;

   initial begin
      tbl[0] = '{4'h0, 4'd1, 4'd3, 4'd1, 8'd0, 32'h1000, 32'h8000,
                 32'h40, 0, 0, 0, 2, 1'b0, 13'd16, 32'h1000, 32'h8000, 1};
      tbl[1] = '{4'h2, 4'd0, 4'd0, 4'd0, 8'd2, 32'h1000, 32'h8000,
                 32'h40, 0, 0, 0, 3, 1'b0, 13'd1, 32'h1080, 32'h0, 3};
      tbl[2] = '{4'h0, 4'd2, 4'd1, 4'd0, 8'd1, 32'h2000, 32'h9000,
                 32'h100, 0, 5, 1, 2, 1'b0, 13'd6, 32'h2100, 32'h9100, 2};
      tbl[3] = '{4'h5, 4'd3, 4'd3, 4'd3, 8'd1, 32'h0, 32'h4000,
                 32'h800, 2, 1, 10, 4, 1'b1, 13'd64, 32'h800, 32'h4800, 2};
      tbl[4] = '{4'h0, 4'd0, 4'd1, 4'd2, 8'd1, 32'h3000, 32'h3400,
                 32'h10, 0, 0, 0, 0, 1'b0, 13'd6, 32'h3010, 32'h3410, 2};
      tbl[5] = '{4'hE, 4'd15, 4'd15, 4'd15, 8'd1, 32'hFFFF_FFC0, 32'h0,
                 32'h40, 3, 0, 2, 1, 1'b1, 13'd4096, 32'h0, 32'h0, 2};

      rst = 1'b0;
      repeat (3) step();
      chk1("rst_done", done, 1'b1);
      chk1("rst_v1", ddr1_cmd_valid, 1'b0);
      chk1("rst_v2", ddr2_cmd_valid, 1'b0);
      chk1("rst_ack", tile_ack, 1'b0);
      chk1("rst_dgs", dg_start, 1'b0);
      chkv("rst_addr", 64'({ddr1_cmd_addr, ddr2_cmd_addr}), 64'(0));
      chkv("rst_len", 64'({ddr1_cmd_len, ddr2_cmd_len}), 64'(0));
      chkv("rst_cfg", 64'(dg_cfg()), 64'(0));
      rst = 1'b1;
      step();

      for (int i = 0; i < 6; i++) begin
         run_layer(tbl[i], 1'b0, acks, llen, l1, l2);
         chkv($sformatf("tbl%0d_len", i), 64'(llen), 64'(tbl[i].exp_len));
         chkv($sformatf("tbl%0d_l1", i), 64'(l1), 64'(tbl[i].exp_l1));
         if (!tbl[i].lt[1])
            chkv($sformatf("tbl%0d_l2", i), 64'(l2), 64'(tbl[i].exp_l2));
         chkv($sformatf("tbl%0d_acks", i), 64'(acks),
              64'(tbl[i].exp_acks));
      end

      // Reset while both commands are pending.
      conf_layer_type = 4'h0;
      conf_ch_num     = 4'd1;
      conf_pix_num    = 4'd1;
      conf_row_num    = 4'd1;
      conf_tile_num   = 8'd3;
      conf_ddr1_base  = 32'h5000;
      conf_ddr2_base  = 32'h6000;
      start = 1'b1;
      step();
      start      = 1'b0;
      tile_valid = 1'b1;
      chk1("mr_busy", done, 1'b0);
      step();
      chk1("mr_v1_pre", ddr1_cmd_valid, 1'b1);
      chk1("mr_v2_pre", ddr2_cmd_valid, 1'b1);
      rst = 1'b0;
      step();
      chk1("mr_v1", ddr1_cmd_valid, 1'b0);
      chk1("mr_v2", ddr2_cmd_valid, 1'b0);
      chk1("mr_done", done, 1'b1);
      chk1("mr_dgs", dg_start, 1'b0);
      chk1("mr_ack", tile_ack, 1'b0);
      chkv("mr_addr", 64'(ddr1_cmd_addr), 64'(0));
      rst        = 1'b1;
      tile_valid = 1'b0;
      step();
      rv = tbl[2];
      rv.b1 = 32'h7000;
      rv.b2 = 32'hA000;
      run_layer(rv, 1'b0, acks, llen, l1, l2);
      chkv("mr_after_l1", 64'(l1), 64'h7100);
      chkv("mr_after_acks", 64'(acks), 64'(2));

      for (int i = 0; i < 8; i++) begin
         rv.lt     = 4'($urandom);
         rv.ch     = 4'($urandom);
         rv.pix    = 4'($urandom);
         rv.row    = 4'($urandom);
         rv.tiles  = 8'($urandom_range(0, 4));
         rv.b1     = $urandom;
         rv.b2     = $urandom;
         rv.stride = $urandom;
         rv.poke   = 1'($urandom);
         run_layer(rv, 1'b1, acks, llen, l1, l2);
         chkv("rnd_acks", 64'(acks), 64'(int'(rv.tiles) + 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_sched.md
# wb_sched

Write-back scheduler for the DDR output path. It sequences the DDR-to-PE data generator (`ddr2pe_dg`) across all output tiles of a layer. For each tile it:
- waits for the PE array to hand over a filled accumulation buffer;
- issues the DDR write commands on both DDR channels;
- starts the data generator and waits for it to finish;
- releases the buffer back to the PE array.

## Interface

Parameters:
- `DDR_AW`, 32, DDR byte-address width.
- `TILE_W`, 8, tile counter width.
- `LEN_W`, 13, burst-length width in DDR words (max 16·16·16 = 4096).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle layer start; ignored unless idle.
- `done`  out  1  high when idle.
- `conf_layer_type`  in  4  bit[1]=1 selects ddr1 only; 0 selects ddr1+ddr2.
- `conf_pooling`, `conf_relu`  in  1 each  passed to the generator.
- `conf_ch_num`, `conf_pix_num`, `conf_row_num`  in  4 each  last index per dimension (count−1).
- `conf_shift`  in  6  passed to the generator.
- `conf_tile_num`  in  TILE_W  last tile index (tiles = value+1).
- `conf_ddr1_base`, `conf_ddr2_base`  in  DDR_AW each  first-tile write address per channel.
- `conf_tile_stride`  in  DDR_AW  address increment per tile.
- `tile_valid`  in  1  level; PE has filled the accumulation buffer for the next tile.
- `tile_ack`  out  1  one-cycle pulse; buffer released.
- `dg_start`  out  1  one-cycle start to the generator.
- `dg_done`  in  1  generator done level.
- `dg_layer_type`, `dg_pooling`, `dg_relu`, `dg_ch_num`, `dg_pix_num`, `dg_row_num`, `dg_shift`  out  (widths as the `conf_*` inputs)  latched config, stable for the whole layer.
- `ddr1_cmd_addr`, `ddr2_cmd_addr`  out  DDR_AW each  burst start address.
- `ddr1_cmd_len`, `ddr2_cmd_len`  out  LEN_W each  burst length in words.
- `ddr1_cmd_valid`, `ddr2_cmd_valid`  out  1 each  command valid.
- `ddr1_cmd_ready`, `ddr2_cmd_ready`  in  1 each  command ready.

## Operation

- **Layer start:** on `start` in `IDLE`, latch all `conf_*`, set `tile_cnt` = 0 and `addr1/addr2` = bases, deassert `done`, go to `WAIT_TILE`.
- **Burst length:** `len = (ch_num+1)·(pix_num+1)·(row_num+1)`.
  - Compute once at latch time, unsigned, LEN_W bits; no overflow is possible.
- **State machine:**
  - `IDLE`: go to `WAIT_TILE` on `start`.
  - `WAIT_TILE`: go to `CMD` when `tile_valid`=1.
  - `CMD`: assert `ddr1_cmd_valid`, plus `ddr2_cmd_valid` if `layer_type[1]`=0.
    - Each valid drops independently on its own valid&ready handshake.
    - Address and length stay stable while valid is high.
    - Go to `KICK` once every required channel has handshaken.
  - `KICK`: `dg_start`=1 for exactly one cycle, go to `RUN`.
  - `RUN`: ignore `dg_done` in the first `RUN` cycle.
    - Afterwards, `dg_done`=1 moves to `ACK`.
  - `ACK`: `tile_ack`=1 for one cycle.
    - Update `addr1/addr2` += stride (mod 2^DDR_AW).
    - If `tile_cnt == tile_num`: go to `IDLE` and set `done`.
    - Otherwise `tile_cnt`++ and go to `WAIT_TILE`.
- **Ignored inputs:** `start` outside `IDLE`; `tile_valid` outside `WAIT_TILE`.
- **Reset (any state, including mid-burst):** next edge gives `IDLE`, all valids/pulses 0, `done`=1, counters 0.

## Timing

- Reset values:
  - `done`=1.
  - `tile_ack`, `dg_start`, `ddr*_cmd_valid` = 0.
  - `ddr*_cmd_addr`, `ddr*_cmd_len`, `dg_*` = 0.
- All outputs are registered; no combinational path from any input to any output.
- Start sequence:
  - `start` at cycle 0: `done` low and state `WAIT_TILE` at cycle 1.
  - `tile_valid` sampled at cycle n: `cmd_valid` high at n+1.
  - Handshake completes in the cycle where valid&ready are both high; valid is low the next cycle.
- Last handshake at cycle m: `dg_start` high at m+1.
- `dg_done` sampled at cycle r: `tile_ack` high at r+1. On the final tile, `done` also rises at r+1.
- Minimum tile overhead with ready=1: 4 cycles plus generator runtime.

## Structure

- Package `wb_pkg` holds:
  - state enum `wb_state_t` {IDLE, WAIT_TILE, CMD, KICK, RUN, ACK};
  - `LEN_W` default;
  - struct `wb_conf_t` bundling the latched configuration.
- Sub-module `wb_cmd_chan`: one command channel. It holds valid until handshake, registers addr/len, and reports `sent`. Instantiated twice.

## Test plan

- **Single tile, ddr1+ddr2:** base1=0x1000, base2=0x8000, ch=1/pix=3/row=1, ready=1.
  - Both cmds show len=16; `dg_start` 1 cycle after the handshake.
  - `tile_ack` and `done` 1 cycle after `dg_done`.
- **Three tiles, stride 0x40, layer_type[1]=1:**
  - ddr1 addrs 0x1000/0x1040/0x1080.
  - `ddr2_cmd_valid` never asserts; exactly 3 `tile_ack` pulses.
- **Backpressure:** ddr2 ready delayed 5 cycles.
  - ddr1 valid drops after its handshake; ddr2 valid is held with stable addr/len.
  - `dg_start` waits for the ddr2 handshake.
- **Stalls:** `tile_valid` low for 10 cycles → FSM holds in `WAIT_TILE` with no cmd valid. A `start` pulse mid-layer has no effect.
- **Stale done:** `dg_done` held high through `KICK`/the first `RUN` cycle → no premature `tile_ack`.
- **Reset:** `rst`=0 during `CMD` with valid high → next cycle valid=0, `done`=1. A new `start` then runs cleanly from tile 0.
